// File: rtl/butterfly_pipe.sv
// Pipelined modular butterfly (CT / GS / GS-half / dual scale) with valid/ready and a sideband tag.
// Latency MUL_LAT+2 cycles; an output stall freezes every stage in lock-step, in_ready = !stall.
module butterfly_pipe #(
  parameter int W       = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 4,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic [W-1:0]     zeta,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [TAG_W-1:0] tag_out
);
  localparam logic [1:0]     MODE_CT    = 2'b00;
  localparam logic [1:0]     MODE_GS    = 2'b01;
  localparam logic [1:0]     MODE_GSH   = 2'b10;
  localparam logic [1:0]     MODE_SCALE = 2'b11;
  localparam logic [W:0]     QW = (W+1)'(Q);
  localparam logic [2*W-1:0] QP = (2*W)'(Q);

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= QW) t = t - QW;
    return t[W-1:0];
  endfunction

  // Borrow out of the W+1-bit difference shows up in the top bit.
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (t[W]) t = t + QW;
    return t[W-1:0];
  endfunction

  // x/2 mod Q: odd values borrow one Q so the shift is exact.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] t;
    t = {1'b0, x};
    if (x[0]) t = t + QW;
    t = t >> 1;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] red_mod(input logic [2*W-1:0] p);
    return W'(p % QP);
  endfunction

  logic stall;
  logic en;
  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  // Stage 0 operands
  logic             v0;
  logic [1:0]       mode0;
  logic [W-1:0]     a0, b0, z0, s0, d0;
  logic [TAG_W-1:0] tag0;

  // Multiplier stages 1..MUL_LAT plus matching bypass registers
  logic [MUL_LAT:1] vld_p;
  logic [2*W-1:0]   p0_p  [1:MUL_LAT];
  logic [2*W-1:0]   p1_p  [1:MUL_LAT];
  logic [W-1:0]     a_p   [1:MUL_LAT];
  logic [W-1:0]     s_p   [1:MUL_LAT];
  logic [1:0]       mode_p[1:MUL_LAT];
  logic [TAG_W-1:0] tag_p [1:MUL_LAT];

  logic [W-1:0]   m0_x, m1_x;
  logic [2*W-1:0] prod0, prod1;

  always_comb begin
    m0_x = d0;
    m1_x = '0;
    case (mode0)
      MODE_CT:    m0_x = b0;
      MODE_SCALE: begin
        m0_x = a0;
        m1_x = b0;
      end
      default:    m0_x = d0;
    endcase
  end

  assign prod0 = (2*W)'(z0) * (2*W)'(m0_x);
  assign prod1 = (2*W)'(z0) * (2*W)'(m1_x);

  logic [W-1:0] m0, m1, a_last, s_last;
  logic [W-1:0] a_nxt, b_nxt;

  assign m0     = red_mod(p0_p[MUL_LAT]);
  assign m1     = red_mod(p1_p[MUL_LAT]);
  assign a_last = a_p[MUL_LAT];
  assign s_last = s_p[MUL_LAT];

  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    case (mode_p[MUL_LAT])
      MODE_CT: begin
        a_nxt = add_mod(a_last, m0);
        b_nxt = sub_mod(a_last, m0);
      end
      MODE_GS: begin
        a_nxt = s_last;
        b_nxt = m0;
      end
      MODE_GSH: begin
        a_nxt = half_mod(s_last);
        b_nxt = half_mod(m0);
      end
      default: begin
        a_nxt = m0;
        b_nxt = m1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0        <= 1'b0;
      vld_p     <= '0;
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      tag_out   <= '0;
    end else if (en) begin
      v0    <= in_valid;
      mode0 <= mode;
      a0    <= a_in;
      b0    <= b_in;
      z0    <= zeta;
      s0    <= add_mod(a_in, b_in);
      d0    <= sub_mod(a_in, b_in);
      tag0  <= tag_in;

      vld_p[1]  <= v0;
      p0_p[1]   <= prod0;
      p1_p[1]   <= prod1;
      a_p[1]    <= a0;
      s_p[1]    <= s0;
      mode_p[1] <= mode0;
      tag_p[1]  <= tag0;
      for (int i = 2; i <= MUL_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        p0_p[i]   <= p0_p[i-1];
        p1_p[i]   <= p1_p[i-1];
        a_p[i]    <= a_p[i-1];
        s_p[i]    <= s_p[i-1];
        mode_p[i] <= mode_p[i-1];
        tag_p[i]  <= tag_p[i-1];
      end

      out_valid <= vld_p[MUL_LAT];
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      tag_out   <= tag_p[MUL_LAT];
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors, random beats vs. an arithmetic model,
// backpressure, bubble and mid-flight reset sequences.
module tb_butterfly_pipe;
  localparam int W = 12, Q = 3329, MUL_LAT = 4, TAG_W = 8, LAT = MUL_LAT + 2;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       mode;
  logic [W-1:0]     a_in, b_in, zeta, a_out, b_out;
  logic [TAG_W-1:0] tag_in, tag_out;

  butterfly_pipe #(.W(W), .Q(Q), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a_in(a_in), .b_in(b_in), .zeta(zeta), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .a_out(a_out), .b_out(b_out), .tag_out(tag_out));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] m; int a; int b; int z; logic [7:0] t; int ea; int eb;} vec_t;
  typedef struct {int a; int b; logic [7:0] t;} want_t;

  int        checks = 0, errors = 0;
  want_t     want_q[$];
  bit        sb_on = 0;
  int        rdy_mode = 0, hold_cnt = 0, stall_seen = 0;
  logic      stall_prev = 0;
  logic [W-1:0] pa, pb;
  logic [7:0]   pt;
  vec_t      tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Model from modular arithmetic; halving is multiplication by the inverse of 2.
  function automatic void ref_bfly(input logic [1:0] m, input int a, input int b, input int z,
                                   output int ea, output int eb);
    int s, d, inv2, zb;
    inv2 = (Q + 1) / 2;
    s = (a + b) % Q;
    d = (a - b + Q) % Q;
    zb = (z * b) % Q;
    case (m)
      2'd0: begin ea = (a + zb) % Q; eb = (a - zb + Q) % Q; end
      2'd1: begin ea = s; eb = (z * d) % Q; end
      2'd2: begin ea = (s * inv2) % Q; eb = (((z * d) % Q) * inv2) % Q; end
      default: begin ea = (z * a) % Q; eb = zb; end
    endcase
  endfunction

  task automatic present(input logic [1:0] m, input int a, input int b, input int z, input logic [7:0] t);
    int guard = 0;
    want_t w;
    @(negedge clk);
    in_valid = 1'b1; mode = m; a_in = W'(a); b_in = W'(b); zeta = W'(z); tag_in = t;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck low, required 1");
    end
    ref_bfly(m, a, b, z, w.a, w.b);
    w.t = t;
    want_q.push_back(w);
  endtask

  task automatic present_rand(input logic [7:0] t);
    present(2'($urandom_range(0, 3)), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
            $urandom_range(0, Q-1), t);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (want_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", want_q.size(), 0);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    in_valid = 1'b1; mode = v.m; a_in = W'(v.a); b_in = W'(v.b); zeta = W'(v.z); tag_in = v.t;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT);
    chk("vec_a", a_out, v.ea);
    chk("vec_b", b_out, v.eb);
    chk("vec_tag", tag_out, v.t);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (hold_cnt >= 3) out_ready = 1'($urandom_range(0, 1));
          else if (out_valid) begin out_ready = 1'b0; hold_cnt++; end
          else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard: order, data, tag, stall stability and in_ready rule.
  always @(negedge clk) begin
    want_t w;
    if (sb_on) begin
      if (stall_prev) begin
        chk("stall_hold_vld", out_valid, 1);
        chk("stall_hold_a", a_out, pa);
        chk("stall_hold_b", b_out, pb);
        chk("stall_hold_tag", tag_out, pt);
      end
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (want_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: tag %0d emitted, required none", tag_out);
        end else begin
          w = want_q.pop_front();
          chk("sb_a", a_out, w.a);
          chk("sb_b", b_out, w.b);
          chk("sb_tag", tag_out, w.t);
        end
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) stall_seen++;
      pa = a_out; pb = b_out; pt = tag_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[5];
    logic ov[14];
    int stale;
    tbl[0] = '{2'd0, 1, 2, 17, 8'h5A, 35, 3296};
    tbl[1] = '{2'd1, 5, 3, 17, 8'h11, 8, 34};
    tbl[2] = '{2'd2, 5, 4, 1, 8'h22, 1669, 1665};
    tbl[3] = '{2'd3, 2, 3, 1000, 8'h33, 2000, 3000};
    tbl[4] = '{2'd0, 3328, 3328, 3328, 8'h44, 0, 3327};
    tbl[5] = '{2'd1, 0, 1, 3328, 8'h55, 1, 1};
    tbl[6] = '{2'd2, 3328, 3328, 5, 8'h66, 3328, 0};
    tbl[7] = '{2'd3, 5, 7, 0, 8'hFF, 0, 0};

    reset = 1'b1; in_valid = 1'b0; mode = '0; a_in = '0; b_in = '0; zeta = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_tag", tag_out, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    repeat (3) @(negedge clk);

    // Backpressure: 8 back-to-back beats, 3-cycle stall on first output, then random ready.
    sb_on = 1; hold_cnt = 0; stall_seen = 0; rdy_mode = 2;
    for (int t = 0; t < 8; t++)
      present(2'(t % 4), $urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1), 8'(t));
    drain();
    chk("bp_stall_seen", stall_seen >= 3, 1);

    // Random beats with bubbles and random ready.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      present_rand(8'(i));
    end
    drain();

    // Bubble pattern must reappear unchanged LAT cycles later.
    pat = '{1, 0, 1, 1, 0};
    for (int k = 0; k < 14; k++) begin
      want_t w;
      @(negedge clk);
      if (k < 5 && pat[k] == 1) begin
        in_valid = 1'b1; mode = 2'd1; a_in = W'(k); b_in = 12'd1; zeta = 12'd2; tag_in = 8'(k);
        ref_bfly(2'd1, k, 1, 2, w.a, w.b);
        w.t = 8'(k);
        want_q.push_back(w);
      end else begin
        in_valid = 1'b0;
      end
      ov[k] = out_valid;
    end
    for (int k = 0; k < 14; k++)
      chk("bubble_vld", ov[k], (k >= LAT && k - LAT < 5) ? pat[k-LAT] : 0);
    drain();

    // Mid-flight reset flushes the four in-flight beats.
    sb_on = 0;
    for (int i = 0; i < 4; i++) present_rand(8'(i + 8'h80));
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    want_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_a", a_out, 0);
    chk("flush_b", b_out, 0);
    chk("flush_tag", tag_out, 0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
